tetris_playfield_avl: RTL and testbench

TETRIS_PLAYFIELD_AVL -- requirements
Module: tetris_playfield_avl

---
 rtl/tetris_playfield_avl.sv | 218 +++++++++++++++++++++
 tb/tb_tetris_playfield_avl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_playfield_avl.sv
// Tetris playfield renderer with an Avalon-MM slave for the cell grid, palette and control.
// The optional cell grid overlay is built only when TETRIS_PLAYFIELD_GRID_EN is defined.
module tetris_playfield_avl #(
  parameter int unsigned COLS    = 10,
  parameter int unsigned ROWS    = 20,
  parameter int unsigned CELL_PX = 24,
  parameter int unsigned X0      = 200,
  parameter int unsigned Y0      = 0,
  parameter int unsigned IDX_W   = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        AVL_READ,
  input  logic        AVL_WRITE,
  input  logic        AVL_CS,
  input  logic [3:0]  AVL_BYTE_EN,
  input  logic [10:0] AVL_ADDR,
  input  logic [31:0] AVL_WRITEDATA,
  output logic [31:0] AVL_READDATA,
  input  logic        PIX_EN,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic        FRAME_START,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  localparam int unsigned NCELL = ROWS * COLS;
  localparam int unsigned NPAL  = 1 << IDX_W;
  localparam int unsigned CI_W  = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int unsigned FW    = COLS * CELL_PX;
  localparam int unsigned FH    = ROWS * CELL_PX;
  localparam int unsigned SUB_W = 10;
  localparam int unsigned RC_W  = 6;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_PX - 1);

  typedef enum logic [1:0] {M_IDLE = 2'd0, M_PLAY = 2'd1, M_OVER = 2'd2} mode_t;

  mode_t mode_q, mode_d;

  logic [IDX_W-1:0] cells [NCELL];
  logic [11:0]      pal   [NPAL];

  logic [1:0]  req_q;
  logic [11:0] bg_q;
  logic        tog_q, frame_ok_q;
  logic [7:0]  fcnt_q;

  logic acc_rd, acc_wr, hit_cell, hit_pal, hit_ctrl;
  logic [CI_W-1:0]  cell_a, rd_a;
  logic [IDX_W-1:0] pal_a;

  logic [SUB_W-1:0] xsub_q, ysub_q, cur_xsub, cur_ysub, ysub_line;
  logic [RC_W-1:0]  col_q, row_q, cur_col, cur_row, row_line;
  logic             x_start, y_start, x_wrap, in_field;
  logic [31:0]      dx, dy;
  logic [10:0]      rd_idx;

  logic             s1_valid, s1_in, s1_grid;
  logic [IDX_W-1:0] s1_idx;
  logic [11:0]      pix_c;

  logic unused_bits;

  // Avalon address decode
  always_comb begin
    acc_rd   = AVL_CS & AVL_READ;
    acc_wr   = AVL_CS & AVL_WRITE;
    hit_cell = 32'(AVL_ADDR) < NCELL;
    hit_pal  = (AVL_ADDR[10] == 1'b1) && (32'(AVL_ADDR[9:0]) < NPAL);
    hit_ctrl = AVL_ADDR == 11'h7FF;
    cell_a   = CI_W'(AVL_ADDR);
    pal_a    = IDX_W'(AVL_ADDR);
  end

  // Cell and palette storage (not reset)
  always_ff @(posedge CLK) begin
    if (acc_wr && hit_cell && AVL_BYTE_EN[0]) cells[cell_a] <= AVL_WRITEDATA[IDX_W-1:0];
    if (acc_wr && hit_pal) begin
      if (AVL_BYTE_EN[0]) pal[pal_a][7:0]  <= AVL_WRITEDATA[7:0];
      if (AVL_BYTE_EN[1]) pal[pal_a][11:8] <= AVL_WRITEDATA[11:8];
    end
  end

  // Control register and frame status
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      req_q      <= 2'd0;
      bg_q       <= 12'd0;
      tog_q      <= 1'b0;
      fcnt_q     <= 8'd0;
      frame_ok_q <= 1'b0;
    end else begin
      if (FRAME_START) begin
        tog_q      <= ~tog_q;
        fcnt_q     <= fcnt_q + 8'd1;
        frame_ok_q <= 1'b1;
      end
      if (acc_wr && hit_ctrl) begin
        if (AVL_BYTE_EN[0]) begin
          req_q     <= AVL_WRITEDATA[1:0];
          bg_q[3:0] <= AVL_WRITEDATA[7:4];
        end
        if (AVL_BYTE_EN[1]) bg_q[11:4] <= AVL_WRITEDATA[15:8];
      end
    end
  end

  // Mode state register
  always_ff @(posedge CLK) begin
    if (!RESET) mode_q <= M_IDLE;
    else        mode_q <= mode_d;
  end

  // Mode next state: the request is only adopted at a frame boundary
  always_comb begin
    mode_d = mode_q;
    if (FRAME_START) begin
      case (req_q)
        2'd1:    mode_d = M_PLAY;
        2'd2:    mode_d = M_OVER;
        default: mode_d = M_IDLE;
      endcase
    end
  end

  // Read data, valid for exactly one cycle after the request
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      AVL_READDATA <= 32'd0;
    end else if (acc_rd) begin
      if (hit_cell)      AVL_READDATA <= 32'(cells[cell_a]);
      else if (hit_pal)  AVL_READDATA <= 32'(pal[pal_a]);
      else if (hit_ctrl) AVL_READDATA <= {fcnt_q, 7'd0, tog_q, bg_q, 2'd0, req_q};
      else               AVL_READDATA <= 32'd0;
    end else begin
      AVL_READDATA <= 32'd0;
    end
  end

  // Current cell position from per-axis counters that restart at the field edge
  always_comb begin
    x_start   = DrawX == 10'(X0);
    y_start   = DrawY == 10'(Y0);
    cur_xsub  = x_start ? '0 : xsub_q;
    cur_col   = x_start ? '0 : col_q;
    x_wrap    = cur_xsub == SUB_LAST;
    ysub_line = y_start ? '0 : ((ysub_q == SUB_LAST) ? '0 : ysub_q + SUB_W'(1));
    row_line  = y_start ? '0 : ((ysub_q == SUB_LAST) ? row_q + RC_W'(1) : row_q);
    cur_ysub  = x_start ? ysub_line : ysub_q;
    cur_row   = x_start ? row_line : row_q;
    dx        = 32'(DrawX) - X0;
    dy        = 32'(DrawY) - Y0;
    in_field  = (dx < FW) && (dy < FH);
    rd_idx    = 11'(cur_row) * 11'(COLS) + 11'(cur_col);
    rd_a      = in_field ? CI_W'(rd_idx) : '0;
  end

  // Counter state advances once per pixel; the row counter once per line
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      xsub_q <= '0;
      col_q  <= '0;
      ysub_q <= '0;
      row_q  <= '0;
    end else if (PIX_EN) begin
      xsub_q <= x_wrap ? '0 : cur_xsub + SUB_W'(1);
      col_q  <= x_wrap ? cur_col + RC_W'(1) : cur_col;
      if (x_start) begin
        ysub_q <= cur_ysub;
        row_q  <= cur_row;
      end
    end
  end

  // Stage-2 colour selection
  always_comb begin
    pix_c = 12'h000;
    if (s1_valid) begin
      if (mode_q == M_IDLE || !s1_in) pix_c = bg_q;
`ifdef TETRIS_PLAYFIELD_GRID_EN
      else if (s1_grid)               pix_c = 12'h444;
`endif
      else if (s1_idx == '0)          pix_c = bg_q;
      else if (mode_q == M_OVER)      pix_c = pal[IDX_W'(NPAL - 1)];
      else                            pix_c = pal[s1_idx];
    end
  end

  // Two-stage pixel pipeline: cell fetch, then colour output
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      s1_valid <= 1'b0;
      s1_in    <= 1'b0;
      s1_grid  <= 1'b0;
      s1_idx   <= '0;
      red      <= 4'd0;
      green    <= 4'd0;
      blue     <= 4'd0;
    end else if (PIX_EN) begin
      s1_valid <= blank & (frame_ok_q | FRAME_START);
      s1_in    <= in_field;
      s1_idx   <= cells[rd_a];
`ifdef TETRIS_PLAYFIELD_GRID_EN
      s1_grid  <= in_field && (cur_xsub == '0 || cur_ysub == '0);
`else
      s1_grid  <= 1'b0;
`endif
      {red, green, blue} <= pix_c;
    end
  end

  // Bits that carry no function in this register map
  always_comb unused_bits = ^{AVL_WRITEDATA[31:16], AVL_BYTE_EN[3:2], rd_idx, s1_grid};

endmodule

// File: tb/tb_tetris_playfield_avl.sv
// Randomized scoreboard bench for tetris_playfield_avl against a geometric reference model.
module tb_tetris_playfield_avl;
  localparam int COLS = 10, ROWS = 20, CELL_PX = 24, X0 = 200, Y0 = 0, IDX_W = 3;
  localparam int NPAL = 8, NCELL = COLS * ROWS;
  localparam int X1 = X0 + COLS * CELL_PX, Y1 = Y0 + ROWS * CELL_PX;

  logic CLK, RESET, AVL_READ, AVL_WRITE, AVL_CS, PIX_EN, blank, FRAME_START;
  logic [3:0] AVL_BYTE_EN, red, green, blue;
  logic [10:0] AVL_ADDR;
  logic [31:0] AVL_WRITEDATA, AVL_READDATA;
  logic [9:0] DrawX, DrawY;

  tetris_playfield_avl #(.COLS(COLS), .ROWS(ROWS), .CELL_PX(CELL_PX), .X0(X0), .Y0(Y0), .IDX_W(IDX_W)) dut (
    .CLK(CLK), .RESET(RESET), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
    .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA(AVL_READDATA), .PIX_EN(PIX_EN), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .FRAME_START(FRAME_START), .red(red), .green(green), .blue(blue));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state
  int cells_m [NCELL];
  int pal_m [NPAL];
  int bg_m, req_m, mode_m, tog_m, fcnt_m;
  bit fok_m;

  typedef struct { int due; int rgb; int x; int y; } pexp_t;
  pexp_t pq[$];
  int rq[$];
  int edges = 0;
  int n_cmp = 0, n_bad = 0;
  bit mon_en = 1'b0;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  function automatic int exp_pix(int x, int y, bit b);
    int c;
    if (!b || !fok_m) return 0;
    if (mode_m == 0) return bg_m;
    if (x < X0 || x >= X1 || y < Y0 || y >= Y1) return bg_m;
`ifdef TETRIS_PLAYFIELD_GRID_EN
    if ((x - X0) % CELL_PX == 0 || (y - Y0) % CELL_PX == 0) return 'h444;
`endif
    c = cells_m[((y - Y0) / CELL_PX) * COLS + (x - X0) / CELL_PX];
    if (c == 0) return bg_m;
    return (mode_m == 2) ? pal_m[NPAL-1] : pal_m[c];
  endfunction

  function automatic int read_m(int a);
    if (a < NCELL) return cells_m[a];
    if (a >= 'h400 && a < 'h400 + NPAL) return pal_m[a - 'h400];
    if (a == 'h7FF) return (fcnt_m << 24) | (tog_m << 16) | (bg_m << 4) | req_m;
    return 0;
  endfunction

  function automatic void write_m(int a, int d, logic [3:0] be);
    if (a < NCELL) begin
      if (be[0]) cells_m[a] = d & (NPAL - 1);
    end else if (a >= 'h400 && a < 'h400 + NPAL) begin
      if (be[0]) pal_m[a-'h400] = (pal_m[a-'h400] & 'hF00) | (d & 'hFF);
      if (be[1]) pal_m[a-'h400] = (pal_m[a-'h400] & 'h0FF) | (d & 'hF00);
    end else if (a == 'h7FF) begin
      if (be[0]) begin
        req_m = d & 3;
        bg_m  = (bg_m & 'hFF0) | ((d >> 4) & 'hF);
      end
      if (be[1]) bg_m = (bg_m & 'h00F) | (((d >> 8) & 'hFF) << 4);
    end
  endfunction

  function automatic void frame_m();
    tog_m  = tog_m ^ 1;
    fcnt_m = (fcnt_m + 1) % 256;
    mode_m = (req_m == 1) ? 1 : (req_m == 2) ? 2 : 0;
    fok_m  = 1'b1;
  endfunction

  function automatic void reset_m();
    req_m = 0; bg_m = 0; mode_m = 0; tog_m = 0; fcnt_m = 0; fok_m = 1'b0;
  endfunction

  // Monitor: Avalon read data
  always @(posedge CLK) begin
    automatic bit was_rd = AVL_CS && AVL_READ;
    #1;
    if (mon_en) begin
      if (was_rd) begin
        if (rq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rd_unexpected: got %0h want none", AVL_READDATA);
        end else chk("readdata", int'(AVL_READDATA), rq.pop_front());
      end else chk("readdata_idle", int'(AVL_READDATA), 0);
    end
  end

  // Monitor: pixel outputs, due two PIX_EN edges after issue
  always @(posedge CLK) begin
    if (PIX_EN) edges++;
    #1;
    while (pq.size() > 0 && pq[0].due <= edges) begin
      automatic pexp_t e = pq.pop_front();
      n_cmp++;
      if (int'({red, green, blue}) != e.rgb) begin
        n_bad++;
        $display("FAIL pixel (%0d,%0d): got %03h want %03h", e.x, e.y, {red, green, blue}, e.rgb);
      end
    end
  end

  task automatic idle();
    AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0; AVL_BYTE_EN = 0; AVL_ADDR = 0; AVL_WRITEDATA = 0;
    PIX_EN = 0; FRAME_START = 0;
  endtask

  task automatic wr(int a, int d, logic [3:0] be);
    AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 11'(a); AVL_WRITEDATA = 32'(d); AVL_BYTE_EN = be;
    write_m(a, d, be);
    @(negedge CLK); idle();
  endtask

  task automatic rd(int a);
    AVL_CS = 1; AVL_READ = 1; AVL_ADDR = 11'(a);
    rq.push_back(read_m(a));
    @(negedge CLK); idle();
  endtask

  task automatic pix(int x, int y, bit b);
    PIX_EN = 1; DrawX = 10'(x); DrawY = 10'(y); blank = b;
    pq.push_back('{edges + 2, exp_pix(x, y, b), x, y});
    @(negedge CLK); PIX_EN = 0;
  endtask

  task automatic pix_wr(int x, int y, int a, int d);
    PIX_EN = 1; DrawX = 10'(x); DrawY = 10'(y); blank = 1;
    pq.push_back('{edges + 2, exp_pix(x, y, 1), x, y});
    AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 11'(a); AVL_WRITEDATA = 32'(d); AVL_BYTE_EN = 4'hF;
    write_m(a, d, 4'hF);
    @(negedge CLK); idle();
  endtask

  task automatic flush();
    pix(0, 0, 0);
    pix(0, 0, 0);
  endtask

  task automatic fs();
    flush();
    FRAME_START = 1;
    frame_m();
    @(negedge CLK); FRAME_START = 0;
  endtask

  task automatic fs_wr(int d);
    flush();
    FRAME_START = 1;
    AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 11'h7FF; AVL_WRITEDATA = 32'(d); AVL_BYTE_EN = 4'hF;
    frame_m();
    write_m('h7FF, d, 4'hF);
    @(negedge CLK); idle();
  endtask

  // A full line scans across the field with random stalls; others touch only the field edge
  task automatic line(int y, bit full);
    if (!full) pix(X0, y, 1'b1);
    else for (int x = X0 - 2; x <= X1 + 1; x++) begin
      if ($urandom_range(0, 5) == 0) begin
        DrawX = 10'($urandom_range(0, 1023)); DrawY = 10'($urandom_range(0, 1023));
        repeat ($urandom_range(1, 3)) @(negedge CLK);
      end
      pix(x, y, $urandom_range(0, 15) != 0);
    end
  endtask

  task automatic scan(int n);
    for (int y = 0; y < n; y++)
      line(y, y < 2 || y == 23 || y == 24 || y == Y1 - 1 || y == Y1 || $urandom_range(0, 39) == 0);
    flush();
  endtask

  task automatic do_reset(int n);
    RESET = 0; idle();
    repeat (n) @(negedge CLK);
    reset_m();
    pq.delete();
    RESET = 1;
  endtask

  initial begin
    idle(); DrawX = 0; DrawY = 0; blank = 0; RESET = 0;
    repeat (3) @(negedge CLK);
    reset_m(); RESET = 1; mon_en = 1;
    chk("rgb_after_reset", int'({red, green, blue}), 0);
    rd('h7FF);

    for (int i = 0; i < NCELL; i++) wr(i, $urandom_range(0, NPAL - 1), 4'hF);
    for (int k = 0; k < NPAL; k++) wr('h400 + k, $urandom_range(0, 'hFFF), 4'hF);
    wr('h401, 'h0F00, 4'hF); wr(0, 1, 4'hF); wr(1, 0, 4'hF); wr('h7FF, 'h0001, 4'hF);
    fs();
    scan(Y1 + 2);

    wr(200, 5, 4'hF); rd(200); rd(0);

    fs_wr(2);
    scan(26);
    fs();
    scan(Y1 + 2);

    // Cell write coinciding with its render read
    fs();
    for (int x = X0 - 2; x < X0 + 60; x++) begin
      if (x == X0 + CELL_PX) pix_wr(x, 0, 1, 5);
      else pix(x, 0, 1'b1);
    end
    flush();

    // Random register traffic between frames
    for (int i = 0; i < 60; i++) begin
      automatic int a;
      case ($urandom_range(0, 3))
        0: a = $urandom_range(0, NCELL + 20);
        1: a = $urandom_range('h3F8, 'h40F);
        2: a = 'h7FF;
        default: a = $urandom_range(0, 'h7FF);
      endcase
      if ($urandom_range(0, 1) != 0) wr(a, $urandom, 4'($urandom_range(0, 15)));
      rd(a);
    end
    wr('h7FF, 'h0000, 4'hF);
    wr('h7FF, 'h0FF1, 4'b0001);
    rd('h7FF);
    fs();
    scan(30);

    // Reset in the middle of a rendered line
    wr('h7FF, 'h2, 4'h1); wr(0, 3, 4'hF);
    fs();
    pix(X0, 0, 1); pix(X0 + 1, 0, 1); pix(X0 + 2, 0, 1);
    do_reset(1);
    chk("rgb_mid_reset", int'({red, green, blue}), 0);
    pix(X0, 0, 1); pix(X0 + 1, 0, 1); flush();
    wr('h7FF, 'hABC0, 4'h3);
    pix(X0, 0, 1); pix(X0 + 1, 0, 1); flush();
    fs();
    scan(3);

    // Frame counter wrap from reset
    do_reset(2);
    for (int i = 0; i < 256; i++) begin
      FRAME_START = 1; frame_m(); @(negedge CLK); FRAME_START = 0;
    end
    rd('h7FF);

    PIX_EN = 1; blank = 0;
    repeat (3) @(negedge CLK);
    PIX_EN = 0;
    @(negedge CLK);
    if (pq.size() != 0 || rq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d pending want 0", pq.size() + rq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
